// File: rtl/bus_sequencer_pkg.sv
// Bus frame timing constants and SPI slot state type shared by the
// bus sequencer, its phase counter and anything that needs to know where
// the strobes sit inside the 16-phase frame.
package bus_timing_pkg;

    // SPI slot strobe phases (inside the CPU-released part of the frame)
    localparam int SPI_EN_FIRST = 2;
    localparam int SPI_EN_LAST  = 4;
    localparam int SPI_CAP      = 4;
    localparam int SPI_RDY      = 5;

    // CPU RAM/IO strobe window, nested inside PHI2
    localparam int CPU_EN_FIRST = 12;
    localparam int CPU_EN_LAST  = 14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DONE  = 2'd2
    } spi_slot_state_t;

endpackage

// File: rtl/bus_sequencer_if.sv
// Bundle of the SPI handshake and the CPU/RAM bus strobes produced by
// bus_sequencer. The master side is the sequencer; the slave side is the
// spi1 port plus the bus/RAM glue that consumes the strobes.
interface bus_sequencer_if #(
    parameter int PHASE_W = 4
);
    logic               spi_valid_i;
    logic               spi_ready_o;
    logic               spi_en_o;
    logic               spi_capture_o;
    logic               cpu_be_o;
    logic               cpu_clk_o;
    logic               cpu_en_o;
    logic [PHASE_W-1:0] phase_o;

    modport master (
        input  spi_valid_i,
        output spi_ready_o,
        output spi_en_o,
        output spi_capture_o,
        output cpu_be_o,
        output cpu_clk_o,
        output cpu_en_o,
        output phase_o
    );

    modport slave (
        output spi_valid_i,
        input  spi_ready_o,
        input  spi_en_o,
        input  spi_capture_o,
        input  cpu_be_o,
        input  cpu_clk_o,
        input  cpu_en_o,
        input  phase_o
    );
endinterface

// File: rtl/bus_sequencer_phase_counter.sv
// Frame phase counter plus registered decode of the CPU-side strobes.
// Every output is registered from the *next* phase so that the value
// belonging to phase p is visible in the same cycle that phase reads p.
// CYCLE_LEN must be a power of two (the phase width is its log2).
module bus_phase_counter
    import bus_timing_pkg::*;
#(
    parameter int CYCLE_LEN  = 16,
    parameter int SPI_LEN    = 6,
    parameter int PHI2_START = 11,
    localparam int PHASE_W   = $clog2(CYCLE_LEN)
) (
    input  logic               clk,
    input  logic               srst,
    output logic [PHASE_W-1:0] phase,
    output logic [PHASE_W-1:0] phase_next,
    output logic               cpu_be,
    output logic               cpu_clk,
    output logic               cpu_en
);

    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(CYCLE_LEN - 1);

    logic [PHASE_W-1:0]   phase_reg;
    logic                 cpu_be_reg;
    logic                 cpu_clk_reg;
    logic                 cpu_en_reg;
    logic [CYCLE_LEN-1:0] be_map;
    logic [CYCLE_LEN-1:0] clk_map;
    logic [CYCLE_LEN-1:0] en_map;

    // Constant per-phase lookup tables for the CPU strobes
    genvar gi;
    generate
        for (gi = 0; gi < CYCLE_LEN; gi++) begin : g_decode
            assign be_map[gi]  = (gi >= SPI_LEN);
            assign clk_map[gi] = (gi >= PHI2_START);
            assign en_map[gi]  = (gi >= CPU_EN_FIRST) && (gi <= CPU_EN_LAST);
        end
    endgenerate

    // Modulo increment, wraps from the last phase straight to 0
    always_comb begin
        phase_next = (phase_reg == PHASE_LAST) ? '0 : phase_reg + 1'b1;
    end

    // Phase register and registered CPU strobe decode
    always_ff @(posedge clk) begin
        if (srst) begin
            phase_reg   <= '0;
            cpu_be_reg  <= 1'b0;
            cpu_clk_reg <= 1'b0;
            cpu_en_reg  <= 1'b0;
        end else begin
            phase_reg   <= phase_next;
            cpu_be_reg  <= be_map[phase_next];
            cpu_clk_reg <= clk_map[phase_next];
            cpu_en_reg  <= en_map[phase_next];
        end
    end

    assign phase   = phase_reg;
    assign cpu_be  = cpu_be_reg;
    assign cpu_clk = cpu_clk_reg;
    assign cpu_en  = cpu_en_reg;

endmodule

// File: rtl/bus_sequencer.sv
// Bus sequencer: splits clk_sys_i into a fixed frame holding one 6502 bus
// cycle and one SPI bus slot, and hands the SPI slot to the spi1 command
// port at most once per pending transaction. The CPU timing never depends
// on SPI activity; the SPI slot lives entirely in the phases where the CPU
// bus is released.
module bus_sequencer
    import bus_timing_pkg::*;
#(
    parameter int CYCLE_LEN  = 16,
    parameter int SPI_LEN    = 6,
    parameter int PHI2_START = 11
) (
    input  logic             clk_sys_i,
    input  logic             reset_i,
    bus_sequencer_if.master  bus
);

    localparam int PHASE_W = $clog2(CYCLE_LEN);

    localparam logic [PHASE_W-1:0] PH_LAST     = PHASE_W'(CYCLE_LEN - 1);
    localparam logic [PHASE_W-1:0] PH_EN_FIRST = PHASE_W'(SPI_EN_FIRST);
    localparam logic [PHASE_W-1:0] PH_EN_LAST  = PHASE_W'(SPI_EN_LAST);
    localparam logic [PHASE_W-1:0] PH_CAP      = PHASE_W'(SPI_CAP);
    localparam logic [PHASE_W-1:0] PH_RDY      = PHASE_W'(SPI_RDY);

    logic [PHASE_W-1:0] phase;
    logic [PHASE_W-1:0] phase_next;
    logic               cpu_be;
    logic               cpu_clk;
    logic               cpu_en;

    spi_slot_state_t    state_reg;
    spi_slot_state_t    state_next;
    logic               rearm_reg;
    logic               rearm_next;
    logic               spi_en_reg;
    logic               spi_capture_reg;
    logic               spi_ready_reg;
    logic               in_slot;

    bus_phase_counter #(
        .CYCLE_LEN  (CYCLE_LEN),
        .SPI_LEN    (SPI_LEN),
        .PHI2_START (PHI2_START)
    ) u_phase (
        .clk        (clk_sys_i),
        .srst       (reset_i),
        .phase      (phase),
        .phase_next (phase_next),
        .cpu_be     (cpu_be),
        .cpu_clk    (cpu_clk),
        .cpu_en     (cpu_en)
    );

    assign in_slot = (state_reg == GRANT);

    // Slot handshake: grant only at a frame boundary; after the slot, wait
    // for valid to drop before another grant. rearm remembers a drop seen
    // while the slot was still running so the FSM skips DONE in that case.
    always_comb begin
        state_next = state_reg;
        rearm_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.spi_valid_i && (phase == PH_LAST)) begin
                    state_next = GRANT;
                end
            end
            GRANT: begin
                rearm_next = rearm_reg || !bus.spi_valid_i;
                if (phase_next == PH_RDY) begin
                    rearm_next = 1'b0;
                    state_next = (rearm_reg || !bus.spi_valid_i) ? IDLE : DONE;
                end
            end
            DONE: begin
                if (!bus.spi_valid_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FSM state and registered SPI strobes, decoded from the upcoming phase
    always_ff @(posedge clk_sys_i) begin
        if (reset_i) begin
            state_reg       <= IDLE;
            rearm_reg       <= 1'b0;
            spi_en_reg      <= 1'b0;
            spi_capture_reg <= 1'b0;
            spi_ready_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            rearm_reg       <= rearm_next;
            spi_en_reg      <= in_slot && (phase_next >= PH_EN_FIRST) && (phase_next <= PH_EN_LAST);
            spi_capture_reg <= in_slot && (phase_next == PH_CAP);
            spi_ready_reg   <= in_slot && (phase_next == PH_RDY);
        end
    end

    assign bus.spi_ready_o   = spi_ready_reg;
    assign bus.spi_en_o      = spi_en_reg;
    assign bus.spi_capture_o = spi_capture_reg;
    assign bus.cpu_be_o      = cpu_be;
    assign bus.cpu_clk_o     = cpu_clk;
    assign bus.cpu_en_o      = cpu_en;
    assign bus.phase_o       = phase;

    // The SPI and CPU strobe windows must never overlap on the shared bus
    a_spi_cpu_excl: assert property (@(posedge clk_sys_i) disable iff (reset_i)
        !(spi_en_reg && cpu_en));

    // The FPGA only drives the bus while the CPU is tri-stated
    a_spi_be_excl: assert property (@(posedge clk_sys_i) disable iff (reset_i)
        !(spi_en_reg && cpu_be));

endmodule

// File: tb/tb_bus_sequencer.sv
// Self-checking bench for bus_sequencer: a constant table for the free-run
// frame, hand-written sequences for the handshake corner cases, and random
// valid episodes checked every cycle against a frame-level reference model.
module tb_bus_sequencer;
    import bus_timing_pkg::*;

    logic clk_sys_i = 1'b0;
    logic reset_i   = 1'b1;

    bus_sequencer_if bus ();

    bus_sequencer dut (
        .clk_sys_i (clk_sys_i),
        .reset_i   (reset_i),
        .bus       (bus)
    );

    always #5 clk_sys_i = ~clk_sys_i;

    typedef struct {
        int         ph;
        logic       valid;
        logic [2:0] cpu;   // {be, clk, en}
        logic [2:0] spi;   // {spi_en, capture, ready}
    } vec_t;

    vec_t tbl [16];

    int total = 0;
    int bad   = 0;

    // Reference model: frame-level view of the slot.
    // phase_m counts cycles since reset modulo 16; a grant starts the frame
    // after a phase-15 sample of valid, provided valid has been seen low
    // since the previous grant. grant_base is the cycle index of that frame's
    // phase 0; strobes are offsets from it.
    int cyc        = 0;
    int phase_m    = 0;
    int grant_base = -1000;
    bit armed      = 1'b1;

    int rdy_cnt = 0;
    int en_cnt  = 0;
    int cap_cnt = 0;
    int rdy_ph  = -1;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [9:0] dut_out();
        return {bus.phase_o, bus.cpu_be_o, bus.cpu_clk_o, bus.cpu_en_o,
                bus.spi_en_o, bus.spi_capture_o, bus.spi_ready_o};
    endfunction

    function automatic logic [9:0] model_out();
        int   rel;
        logic be, ck, en;
        rel = cyc - grant_base;
        be  = (phase_m >= 6);
        ck  = (phase_m >= 11);
        en  = (phase_m >= 12) && (phase_m <= 14);
        return {4'(phase_m), be, ck, en,
                (rel >= 2) && (rel <= 4), rel == 4, rel == 5};
    endfunction

    // Advance one clock, updating the model from the inputs seen at the edge
    task automatic tick();
        logic v, r;
        v = bus.spi_valid_i;
        r = reset_i;
        @(posedge clk_sys_i);
        if (r) begin
            phase_m    = 0;
            grant_base = -1000;
            armed      = 1'b1;
        end else begin
            if (v && armed && phase_m == 15) begin
                grant_base = cyc + 1;
                armed      = 1'b0;
            end else if (!v) begin
                armed = 1'b1;
            end
            phase_m = (phase_m + 1) % 16;
        end
        cyc++;
        #1;
    endtask

    task automatic step(input string name);
        tick();
        check(name, 16'(dut_out()), 16'(model_out()));
        check("spi_cpu_excl", 16'(bus.spi_en_o & bus.cpu_en_o), 16'd0);
        check("spi_be_excl", 16'(bus.spi_en_o & bus.cpu_be_o), 16'd0);
        if (bus.spi_ready_o) begin
            rdy_cnt++;
            rdy_ph = phase_m;
        end
        if (bus.spi_en_o)      en_cnt++;
        if (bus.spi_capture_o) cap_cnt++;
    endtask

    task automatic clear_counts();
        rdy_cnt = 0;
        en_cnt  = 0;
        cap_cnt = 0;
        rdy_ph  = -1;
    endtask

    task automatic advance_to(input int ph);
        for (int k = 0; k < 16 && phase_m != ph; k++) step("advance");
    endtask

    initial begin
        int lat;
        int episodes;
        int start;
        int base;
        vec_t vec;

        //               ph  valid cpu{be,clk,en} spi
        tbl[0]  = '{ 0, 1'b0, 3'b000, 3'b000};
        tbl[1]  = '{ 1, 1'b0, 3'b000, 3'b000};
        tbl[2]  = '{ 2, 1'b0, 3'b000, 3'b000};
        tbl[3]  = '{ 3, 1'b0, 3'b000, 3'b000};
        tbl[4]  = '{ 4, 1'b0, 3'b000, 3'b000};
        tbl[5]  = '{ 5, 1'b0, 3'b000, 3'b000};
        tbl[6]  = '{ 6, 1'b0, 3'b100, 3'b000};
        tbl[7]  = '{ 7, 1'b0, 3'b100, 3'b000};
        tbl[8]  = '{ 8, 1'b0, 3'b100, 3'b000};
        tbl[9]  = '{ 9, 1'b0, 3'b100, 3'b000};
        tbl[10] = '{10, 1'b0, 3'b100, 3'b000};
        tbl[11] = '{11, 1'b0, 3'b110, 3'b000};
        tbl[12] = '{12, 1'b0, 3'b111, 3'b000};
        tbl[13] = '{13, 1'b0, 3'b111, 3'b000};
        tbl[14] = '{14, 1'b0, 3'b111, 3'b000};
        tbl[15] = '{15, 1'b0, 3'b110, 3'b000};

        // Reset: everything low, phase 0
        bus.spi_valid_i = 1'b0;
        reset_i = 1'b1;
        repeat (3) step("reset_state");
        check("reset_zero", 16'(dut_out()), 16'd0);
        reset_i = 1'b0;

        // Free-run four frames against the constant frame table
        for (int i = 0; i < 64; i++) begin
            vec = tbl[i % 16];
            bus.spi_valid_i = vec.valid;
            check("freerun", 16'(dut_out()), 16'({4'(vec.ph), vec.cpu, vec.spi}));
            tick();
        end

        // Valid rises at phase 3: nothing this frame, one slot next frame
        advance_to(3);
        bus.spi_valid_i = 1'b1;
        clear_counts();
        repeat (12) step("rise3_frame0");
        check("rise3_no_strobe", 16'(rdy_cnt + en_cnt + cap_cnt), 16'd0);
        repeat (16) step("rise3_frame1");
        check("rise3_en_cnt", 16'(en_cnt), 16'd3);
        check("rise3_cap_cnt", 16'(cap_cnt), 16'd1);
        check("rise3_rdy_cnt", 16'(rdy_cnt), 16'd1);
        check("rise3_rdy_phase", 16'(rdy_ph), 16'd5);

        // Valid held five more frames: no second grant
        clear_counts();
        repeat (80) step("hold");
        check("hold_no_grant", 16'(rdy_cnt + en_cnt), 16'd0);

        // One-cycle drop re-arms: exactly one more grant
        bus.spi_valid_i = 1'b0;
        step("drop1");
        bus.spi_valid_i = 1'b1;
        clear_counts();
        repeat (32) step("rearm");
        check("rearm_rdy_cnt", 16'(rdy_cnt), 16'd1);
        bus.spi_valid_i = 1'b0;
        step("idle");

        // Valid rises at phase 15: ready six cycles later
        advance_to(15);
        bus.spi_valid_i = 1'b1;
        clear_counts();
        lat = 0;
        while (rdy_cnt == 0 && lat < 40) begin
            step("rise15");
            lat++;
        end
        check("rise15_latency", 16'(lat), 16'd6);
        bus.spi_valid_i = 1'b0;
        repeat (2) step("idle");

        // Reset at phase 3 of a granted frame
        advance_to(15);
        bus.spi_valid_i = 1'b1;
        repeat (4) step("pre_reset_grant");
        check("grant_active_ph3", 16'(bus.spi_en_o), 16'd1);
        reset_i = 1'b1;
        clear_counts();
        step("reset_mid_grant");
        check("reset_spi_en_low", 16'(bus.spi_en_o), 16'd0);
        reset_i = 1'b0;
        // still-pending request gets the first frame boundary after release
        lat = 0;
        while (rdy_cnt == 0 && lat < 40) begin
            step("post_reset");
            lat++;
        end
        check("post_reset_latency", 16'(lat), 16'd21);
        check("post_reset_en_cnt", 16'(en_cnt), 16'd3);
        bus.spi_valid_i = 1'b0;
        repeat (2) step("idle");

        // Valid drops during the slot: slot completes, FSM goes idle
        advance_to(15);
        bus.spi_valid_i = 1'b1;
        repeat (2) step("grant_drop");
        bus.spi_valid_i = 1'b0;
        clear_counts();
        repeat (8) step("grant_drop");
        check("drop_slot_rdy", 16'(rdy_cnt), 16'd1);
        check("drop_slot_en", 16'(en_cnt), 16'd3);
        bus.spi_valid_i = 1'b1;
        clear_counts();
        repeat (16) step("after_drop");
        check("after_drop_rdy", 16'(rdy_cnt), 16'd1);
        bus.spi_valid_i = 1'b0;
        step("idle");

        // Random valid episodes, each held until its ready pulse
        episodes = 0;
        clear_counts();
        start = cyc;
        while (cyc - start < 10000) begin
            repeat ($urandom_range(1, 40)) step("rand");
            bus.spi_valid_i = 1'b1;
            episodes++;
            base = rdy_cnt;
            lat = 0;
            while (rdy_cnt == base && lat < 40) begin
                step("rand");
                lat++;
            end
            check("rand_latency_bound", 16'(lat <= 21), 16'd1);
            repeat ($urandom_range(0, 30)) step("rand");
            bus.spi_valid_i = 1'b0;
        end
        repeat (2) step("rand");
        check("rand_one_ready_per_episode", 16'(rdy_cnt), 16'(episodes));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
